// File: rtl/alu_mdu_control_pkg.sv
// alu_mdu_control_pkg: selection codes, funct3/ALUOp constants, M-unit states and base decode
package alu_mdu_control_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd15;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_R    = 3'b010;
    localparam logic [2:0] ALUOP_I    = 3'b011;
    localparam logic [2:0] ALUOP_PASS = 3'b100;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    function automatic logic [3:0] alu_decode(input logic [2:0] op, input logic [2:0] f3,
                                              input logic i30, input logic i25);
        logic [3:0] r;
        r = ALU_PASS;
        if (op == ALUOP_ADD)
            r = ALU_ADD;
        else if (op == ALUOP_SUB)
            r = ALU_SUB;
        else if ((op == ALUOP_R && !i25) || op == ALUOP_I)
            case (f3)
                F3_ADD:  r = (op == ALUOP_R && i30) ? ALU_SUB : ALU_ADD;
                F3_SLL:  r = ALU_SLL;
                F3_SLT:  r = ALU_SLT;
                F3_SLTU: r = ALU_SLTU;
                F3_XOR:  r = ALU_XOR;
                F3_SR:   r = i30 ? ALU_SRA : ALU_SRL;
                F3_OR:   r = ALU_OR;
                F3_AND:  r = ALU_AND;
            endcase
        return r;
    endfunction
endpackage

// File: rtl/alu_mdu_control_md_iter_engine.sv
// md_iter_engine: radix-2 shift-add multiplier / restoring divider, one step per cycle
module md_iter_engine #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            div,
    input  logic [XLEN-1:0] ld_hi,
    input  logic [XLEN-1:0] ld_lo,
    input  logic [XLEN-1:0] ld_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);
    localparam int CW = $clog2(XLEN + 1);
    logic [XLEN-1:0] b;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   sum, t, diff;

    // hi:lo is the product during multiply and remainder:quotient during divide
    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    assign t    = {hi, lo[XLEN-1]};
    assign diff = t - {1'b0, b};
    assign last = cnt == CW'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            b   <= '0;
            cnt <= '0;
        end else if (load) begin
            hi  <= ld_hi;
            lo  <= ld_lo;
            b   <= ld_b;
            cnt <= CW'(XLEN);
        end else if (step) begin
            cnt <= cnt - CW'(1);
            hi  <= div ? (diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
            lo  <= div ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
        end
endmodule

// File: rtl/alu_mdu_control.sv
// alu_mdu_control: ALU selection decode plus control of the iterative RV32M/RV64M unit
module alu_mdu_control
    import alu_mdu_control_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1,
    parameter int SEL_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             inst30,
    input  logic             inst25,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic             md_sel,
    output logic             stall,
    output logic             md_valid,
    output logic [XLEN-1:0]  md_result
);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    md_state_t state, state_nx;
    logic md_op, accept, fast, neg_a, neg_b, neg_p, neg_r, last;
    logic [2:0] f3_q;
    logic [XLEN-1:0] abs_a, abs_b, ld_hi, ld_lo, hi, lo, quot, rem, res;
    logic [2*XLEN-1:0] prod;

    assign alu_sel = SEL_W'(alu_decode(alu_op, funct3, inst30, inst25));
    assign md_op   = in_valid && alu_op == ALUOP_R && inst25;
    assign md_sel  = md_op;
    assign accept  = state == MD_IDLE && md_op && !flush;
    assign neg_a   = (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && op_a[XLEN-1];
    assign neg_b   = (funct3 inside {F3_MULH, F3_DIV, F3_REM}) && op_b[XLEN-1];
    assign abs_a   = neg_a ? -op_a : op_a;
    assign abs_b   = neg_b ? -op_b : op_b;
    // divide by zero and MIN / -1 preload their final quotient/remainder
    assign fast    = FAST_SPECIAL && funct3[2] && (op_b == '0 || (!funct3[0] && op_a == MIN && op_b == '1));
    assign ld_hi   = (fast && op_b == '0) ? op_a : '0;
    assign ld_lo   = fast ? (op_b == '0 ? '1 : MIN) : abs_a;

    md_iter_engine #(.XLEN(XLEN)) u_engine (
        .clk(clk), .rst(rst), .load(accept), .step(state == MD_BUSY), .div(f3_q[2]),
        .ld_hi(ld_hi), .ld_lo(ld_lo), .ld_b(abs_b), .hi(hi), .lo(lo), .last(last)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= MD_IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = MD_IDLE;
        case (state)
            MD_IDLE: state_nx = accept ? (fast ? MD_DONE : MD_BUSY) : MD_IDLE;
            MD_BUSY: state_nx = flush ? MD_IDLE : (last ? MD_DONE : MD_BUSY);
            default: state_nx = MD_IDLE;
        endcase
    end

    always_comb
        stall = state == MD_BUSY || (state == MD_IDLE && md_op && !flush);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            f3_q  <= '0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            f3_q  <= funct3;
            neg_p <= !fast && (neg_a ^ neg_b);
            neg_r <= !fast && neg_a;
        end

    assign prod = neg_p ? -{hi, lo} : {hi, lo};
    assign quot = neg_p ? -lo : lo;
    assign rem  = neg_r ? -hi : hi;
    assign res  = f3_q[2] ? (f3_q[1] ? rem : quot)
                          : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            md_valid  <= 1'b0;
            md_result <= '0;
        end else begin
            md_valid <= state == MD_DONE && !flush;
            if (state == MD_DONE && !flush)
                md_result <= res;
        end
endmodule

// File: tb/tb_alu_mdu_control.sv
// tb_alu_mdu_control: directed vectors for decode, M-ops, fast specials, flush and async reset
module tb_alu_mdu_control;
    import alu_mdu_control_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] alu_op = '0, funct3 = '0;
    logic inst30 = 1'b0, inst25 = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [3:0] alu_sel;
    logic md_sel, stall, md_valid;
    logic [31:0] md_result;
    int checks = 0, failures = 0;

    alu_mdu_control dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct3(funct3), .inst30(inst30), .inst25(inst25),
        .in_valid(in_valid), .flush(flush), .op_a(op_a), .op_b(op_b), .alu_sel(alu_sel),
        .md_sel(md_sel), .stall(stall), .md_valid(md_valid), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [2:0] op, input logic [2:0] f,
                       input logic i30, input logic [3:0] exp);
        @(negedge clk);
        alu_op = op; funct3 = f; inst30 = i30; inst25 = 1'b0; in_valid = 1'b1;
        #1 check(tag, alu_sel, exp);
        check({tag, "_stall"}, {md_sel, stall}, 2'b00);
    endtask

    task automatic start_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = ALUOP_R; funct3 = f; inst25 = 1'b1; inst30 = 1'b0; op_a = a; op_b = b; in_valid = 1'b1;
    endtask

    task automatic run_md(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n, st;
        start_md(f, a, b);
        #1 check({tag, "_pre"}, {md_sel, stall}, 2'b11);
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 32'h5a5a5a5a; op_b = 32'h3c3c3c3c;
        n = 0; st = 0;
        while (!md_valid && n < 100) begin
            st += int'(stall);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_stall"}, st, lat - 1);
        check(tag, md_result, exp);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 check("rst_out", {stall, md_valid, md_sel}, 3'b000);
        check("rst_result", md_result, 0);
        @(negedge clk) rst = 1'b0;

        dec("dec_r_sra", ALUOP_R, F3_SR, 1'b1, ALU_SRA);
        dec("dec_r_srl", ALUOP_R, F3_SR, 1'b0, ALU_SRL);
        dec("dec_r_sub", ALUOP_R, F3_ADD, 1'b1, ALU_SUB);
        dec("dec_r_and", ALUOP_R, F3_AND, 1'b0, ALU_AND);
        dec("dec_i_add", ALUOP_I, F3_ADD, 1'b1, ALU_ADD);
        dec("dec_i_sra", ALUOP_I, F3_SR, 1'b1, ALU_SRA);
        dec("dec_i_sltu", ALUOP_I, F3_SLTU, 1'b1, ALU_SLTU);
        dec("dec_sub", ALUOP_SUB, F3_OR, 1'b0, ALU_SUB);
        dec("dec_pass", ALUOP_PASS, F3_ADD, 1'b0, ALU_PASS);
        dec("dec_undef", 3'b111, F3_XOR, 1'b0, ALU_PASS);
        in_valid = 1'b0;

        run_md("mul", F3_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        @(posedge clk); #1 check("valid_pulse", md_valid, 1'b0);
        run_md("mulh", F3_MULH, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        run_md("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
        run_md("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        run_md("div", F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_md("rem", F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_md("divu", F3_DIVU, 32'd7, 32'd2, 32'd3, 33);
        run_md("remu", F3_REMU, 32'd7, 32'd2, 32'd1, 33);
        run_md("divu_z", F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_md("rem_z", F3_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
        run_md("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        start_md(F3_MUL, 32'd9, 32'd9);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("flush_busy", stall, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_stall", stall, 1'b0);
        n = 0;
        repeat (40) begin
            n += int'(md_valid);
            @(posedge clk); #1;
        end
        check("flush_novalid", n, 0);
        run_md("mul3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

        start_md(F3_MUL, 32'd100, 32'd100);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("arst_out", {stall, md_valid}, 2'b00);
        check("arst_result", md_result, 0);
        @(negedge clk) rst = 1'b0;
        run_md("mul6x7", F3_MUL, 32'd6, 32'd7, 32'd42, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
